// File: rtl/isa_shared_pkg.sv
// Shared ISA encodings (load/store funct3) and the store-unit state type.
package isa_shared;

  typedef enum logic [2:0] {
    L_LB  = 3'b000,
    L_LH  = 3'b001,
    L_LW  = 3'b010,
    L_LBU = 3'b100,
    L_LHU = 3'b101
  } load_function3_e;

  typedef enum logic [2:0] {
    S_SB = 3'b000,
    S_SH = 3'b001,
    S_SW = 3'b010
  } store_function3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1
  } store_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Byte-lane placement of store data into one or two word beats.
// STORE_MISALIGNED_SPLIT_EN: when undefined, misaligned SH/SW are rejected.
module store_lane_align
  import isa_shared::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_beat0_wdata,
  output logic [3:0]  o_beat0_wstrb,
  output logic [31:0] o_beat1_wdata,
  output logic [3:0]  o_beat1_wstrb,
  output logic        o_split,
  output logic        o_fault
);

`ifdef STORE_MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic [4:0] w_shamt;
  logic       w_misaligned;

  assign w_shamt = {i_off, 3'b000};

  always_comb begin
    o_beat0_wdata = '0;
    o_beat0_wstrb = '0;
    o_beat1_wdata = '0;
    o_beat1_wstrb = '0;
    o_split       = 1'b0;
    o_fault       = 1'b0;
    w_misaligned  = 1'b0;
    case (i_funct3)
      S_SB: begin
        o_beat0_wstrb = 4'b0001 << i_off;
        o_beat0_wdata = {24'b0, i_data[7:0]} << w_shamt;
      end
      S_SH: begin
        o_beat0_wstrb = 4'b0011 << i_off;
        o_beat0_wdata = {16'b0, i_data[15:0]} << w_shamt;
        w_misaligned  = i_off[0];
        if (i_off == 2'd3) begin
          o_split       = 1'b1;
          o_beat1_wstrb = 4'b0001;
          o_beat1_wdata = {24'b0, i_data[15:8]};
        end
      end
      S_SW: begin
        o_beat0_wstrb = 4'b1111 << i_off;
        o_beat0_wdata = i_data << w_shamt;
        w_misaligned  = (i_off != 2'd0);
        if (w_misaligned) begin
          o_split       = 1'b1;
          o_beat1_wstrb = 4'b1111 >> (3'd4 - {1'b0, i_off});
          o_beat1_wdata = i_data >> (6'd32 - {1'b0, w_shamt});
        end
      end
      default: o_fault = 1'b1;
    endcase
    // Without split support any store that is not naturally aligned is rejected.
    if (!SplitEn) begin
      o_fault       = o_fault | w_misaligned;
      o_split       = 1'b0;
      o_beat1_wstrb = '0;
      o_beat1_wdata = '0;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store, issues one or two write beats, pulses done/fault.
// STORE_MISALIGNED_SPLIT_EN enables split handling of misaligned SH/SW.
module store_unit
  import isa_shared::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_data,
  input  logic [2:0]        i_req_funct3,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  output logic              o_done,
  output logic              o_fault
);

  store_state_e      r_state, w_state_d;
  logic [ADDR_W-3:0] r_addr_word;
  logic [ADDR_W-3:0] w_addr_next;
  logic [31:0]       r_b0_wdata, r_b1_wdata;
  logic [3:0]        r_b0_wstrb, r_b1_wstrb;
  logic              r_split, r_done, r_fault;

  logic [31:0] w_b0_wdata, w_b1_wdata;
  logic [3:0]  w_b0_wstrb, w_b1_wstrb;
  logic        w_split, w_fault, w_accept, w_finish;

  // Lanes are computed from the live request and captured at accept time.
  store_lane_align u_align (
    .i_off         (i_req_addr[1:0]),
    .i_funct3      (i_req_funct3),
    .i_data        (i_req_data),
    .o_beat0_wdata (w_b0_wdata),
    .o_beat0_wstrb (w_b0_wstrb),
    .o_beat1_wdata (w_b1_wdata),
    .o_beat1_wstrb (w_b1_wstrb),
    .o_split       (w_split),
    .o_fault       (w_fault)
  );

  assign w_addr_next = r_addr_word + {{(ADDR_W-3){1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    o_req_ready = 1'b0;
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (!w_fault) w_state_d = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {r_addr_word, 2'b00};
        o_mem_wdata = r_b0_wdata;
        o_mem_wstrb = r_b0_wstrb;
        if (i_mem_ready) begin
          if (r_split) begin
            w_state_d = ST_BEAT1;
          end else begin
            w_state_d = ST_IDLE;
            w_finish  = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {w_addr_next, 2'b00};
        o_mem_wdata = r_b1_wdata;
        o_mem_wstrb = r_b1_wstrb;
        if (i_mem_ready) begin
          w_state_d = ST_IDLE;
          w_finish  = 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr_word <= '0;
      r_b0_wdata  <= '0;
      r_b0_wstrb  <= '0;
      r_b1_wdata  <= '0;
      r_b1_wstrb  <= '0;
      r_split     <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done  <= w_finish;
      r_fault <= w_accept & w_fault;
      if (w_accept) begin
        r_addr_word <= i_req_addr[ADDR_W-1:2];
        r_b0_wdata  <= w_b0_wdata;
        r_b0_wstrb  <= w_b0_wstrb;
        r_b1_wdata  <= w_b1_wdata;
        r_b1_wstrb  <= w_b1_wstrb;
        r_split     <= w_split;
      end
    end
  end

  assign o_done  = r_done;
  assign o_fault = r_fault;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit; expectations follow STORE_MISALIGNED_SPLIT_EN.
module tb_store_unit;
  import isa_shared::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        fault;

  store_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .i_req_funct3 (req_funct3),
    .o_mem_valid  (mem_valid),
    .i_mem_ready  (mem_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wstrb  (mem_wstrb),
    .o_done       (done),
    .o_fault      (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    bit is_fault;
    int lat;
  } evt_t;

  beat_t beat_q[$];
  evt_t  evt_q[$];
  int    acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.strb = s; b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic exp_evt(input bit f, input int lat);
    evt_t e;
    e.is_fault = f; e.lat = lat;
    evt_q.push_back(e);
  endtask

  // Monitor: compares every valid beat against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (mem_valid) begin
        chk("wstrb_nonzero", {31'b0, mem_wstrb != 4'b0000}, 32'd1);
        if (beat_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got addr 0x%08h strb %b, required none", mem_addr,
                   mem_wstrb);
        end else begin
          chk("beat_addr", mem_addr, beat_q[0].addr);
          chk("beat_strb", {28'b0, mem_wstrb}, {28'b0, beat_q[0].strb});
          chk("beat_data", mem_wdata, beat_q[0].data);
          if (mem_ready) void'(beat_q.pop_front());
        end
      end
      if (done || fault) begin
        if (evt_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got done=%0b fault=%0b, required none", done, fault);
        end else begin
          evt_t e;
          int   a;
          e = evt_q.pop_front();
          a = acc_q.pop_front();
          chk("evt_done", {31'b0, done}, {31'b0, !e.is_fault});
          chk("evt_fault", {31'b0, fault}, {31'b0, e.is_fault});
          if (e.lat >= 0) chk("evt_latency", cyc - a, e.lat);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                      input bit hold, output int acc_cyc);
    int n;
    req_addr = a; req_data = d; req_funct3 = f3; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((beat_q.size() != 0 || evt_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", beat_q.size() + evt_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Aligned word
    exp_beat(32'h100, 4'b1111, 32'hDEADBEEF);
    exp_evt(1'b0, 2);
    send(32'h100, 32'hDEADBEEF, S_SW, 1'b0, a0);
    drain();

    // Byte in top lane
    exp_beat(32'h200, 4'b1000, 32'hA500_0000);
    exp_evt(1'b0, 2);
    send(32'h203, 32'h0000_00A5, S_SB, 1'b0, a0);
    drain();

    // Aligned half in upper lanes
    exp_beat(32'h4, 4'b1100, 32'hABCD_0000);
    exp_evt(1'b0, 2);
    send(32'h6, 32'h1234_ABCD, S_SH, 1'b0, a0);
    drain();

`ifdef STORE_MISALIGNED_SPLIT_EN
    exp_beat(32'h100, 4'b1100, 32'h3344_0000);
    exp_beat(32'h104, 4'b0011, 32'h0000_1122);
    exp_evt(1'b0, 3);
    send(32'h102, 32'h1122_3344, S_SW, 1'b0, a0);
    drain();

    exp_beat(32'h100, 4'b1000, 32'hDD00_0000);
    exp_beat(32'h104, 4'b0111, 32'h00AA_BBCC);
    exp_evt(1'b0, 3);
    send(32'h103, 32'hAABB_CCDD, S_SW, 1'b0, a0);
    drain();

    // Misaligned half inside one word stays single-beat
    exp_beat(32'h4, 4'b0110, 32'h00AB_CD00);
    exp_evt(1'b0, 2);
    send(32'h5, 32'h1234_ABCD, S_SH, 1'b0, a0);
    drain();

    // Second beat address wraps past the top of the address space
    exp_beat(32'hFFFF_FFFC, 4'b1110, 32'h0203_0400);
    exp_beat(32'h0000_0000, 4'b0001, 32'h0000_0001);
    exp_evt(1'b0, 3);
    send(32'hFFFF_FFFD, 32'h0102_0304, S_SW, 1'b0, a0);
    drain();

    // Split half with three stalled cycles on beat0
    mem_ready = 1'b0;
    exp_beat(32'h4, 4'b1000, 32'hEF00_0000);
    exp_beat(32'h8, 4'b0001, 32'h0000_00BE);
    exp_evt(1'b0, 6);
    send(32'h7, 32'h0000_BEEF, S_SH, 1'b0, a0);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    drain();
`else
    exp_evt(1'b1, 1);
    send(32'h102, 32'h1122_3344, S_SW, 1'b0, a0);
    drain();

    exp_evt(1'b1, 1);
    send(32'h103, 32'hAABB_CCDD, S_SW, 1'b0, a0);
    drain();

    exp_evt(1'b1, 1);
    send(32'h5, 32'h1234_ABCD, S_SH, 1'b0, a0);
    drain();

    mem_ready = 1'b0;
    exp_evt(1'b1, 1);
    send(32'h7, 32'h0000_BEEF, S_SH, 1'b0, a0);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    drain();
`endif

    // Illegal funct3
    exp_evt(1'b1, 1);
    send(32'h0, 32'h1234_5678, 3'b011, 1'b0, a0);
    drain();

    // Back-to-back bytes with req_valid held
    exp_beat(32'h10, 4'b0001, 32'h0000_0011);
    exp_evt(1'b0, 2);
    exp_beat(32'h10, 4'b0010, 32'h0000_2200);
    exp_evt(1'b0, 2);
    exp_beat(32'h10, 4'b0100, 32'h0033_0000);
    exp_evt(1'b0, 2);
    send(32'h10, 32'h11, S_SB, 1'b1, a0);
    send(32'h11, 32'h22, S_SB, 1'b1, a1);
    send(32'h12, 32'h33, S_SB, 1'b0, a2);
    chk("b2b_gap1", a1 - a0, 32'd2);
    chk("b2b_gap2", a2 - a1, 32'd2);
    drain();

    // Reset while a beat is stalled abandons the store
`ifdef STORE_MISALIGNED_SPLIT_EN
    exp_beat(32'h100, 4'b1110, 32'hFEF0_0D00);
    exp_beat(32'h104, 4'b0001, 32'h0000_00CA);
    send(32'h101, 32'hCAFE_F00D, S_SW, 1'b0, a0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
`else
    mem_ready = 1'b0;
    exp_beat(32'h100, 4'b1111, 32'hCAFE_F00D);
    send(32'h100, 32'hCAFE_F00D, S_SW, 1'b0, a0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_fault", {31'b0, fault}, 32'd0);
    chk("midrst_pending_beats", beat_q.size(), 32'd1);
    beat_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Normal operation resumes after the abandoned store
    exp_beat(32'h300, 4'b0011, 32'h0000_5A5A);
    exp_evt(1'b0, 2);
    send(32'h300, 32'h0000_5A5A, S_SH, 1'b0, a0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_addr  input  ADDR_W  byte address of store.
REQ-007 req_data  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-008 req_funct3  input  3  store width, store_function3_e.
REQ-009 mem_valid  output  1  write beat valid.
REQ-010 mem_ready  input  1  memory accepts beat.
REQ-011 mem_addr  output  ADDR_W  word-aligned beat address, [1:0] always 0.
REQ-012 mem_wdata  output  32  lane-positioned write data; disabled lanes driven 0.
REQ-013 mem_wstrb  output  4  byte-lane enables.
REQ-014 done  output  1  one-cycle pulse, store completed.
REQ-015 fault  output  1  one-cycle pulse, store rejected; no memory traffic issued.

Function
REQ-016 States IDLE, BEAT0, BEAT1; req_ready = 1 only in IDLE.
REQ-017 Accept on req_valid && req_ready; addr, data, funct3 latched; next state BEAT0, or IDLE with fault pulse next cycle if rejected.
REQ-018 mem_valid = 1 in BEAT0/BEAT1; mem_addr/mem_wdata/mem_wstrb stable while mem_valid && !mem_ready.
REQ-019 BEAT0 handshake: go to BEAT1 if split, else IDLE with done pulse next cycle; BEAT1 handshake: IDLE with done pulse next cycle.
REQ-020 Minimum latency with mem_ready held 1: accept at cycle N, beat0 at N+1, done at N+2 (single beat) or N+3 (split).
REQ-021 done/fault coincide with IDLE; a new request accepted in the done/fault cycle is legal (back-to-back).
REQ-022 off = latched addr[1:0]; BEAT0 mem_addr = {addr[ADDR_W-1:2],2'b00}; BEAT1 mem_addr = BEAT0 address + 4, wrapping modulo 2^ADDR_W.
REQ-023 S_SB: wstrb = 4'b0001 << off; wdata = {24'b0,data[7:0]} << 8*off; never split.
REQ-024 S_SH: wstrb = 4'b0011 << off truncated to 4 bits; wdata = data[15:0] << 8*off truncated; off=3 splits: BEAT1 wstrb 4'b0001, wdata = {24'b0,data[15:8]}.
REQ-025 S_SW: BEAT0 wstrb = 4'b1111 << off, wdata = data << 8*off; off!=0 splits: BEAT1 wstrb = 4'b1111 >> (4-off), wdata = data >> 8*(4-off).
REQ-026 req_funct3 not in {S_SB,S_SH,S_SW} SHALL fault.
REQ-027 mem_wstrb never 4'b0000 while mem_valid = 1.

Reset
REQ-028 rst_n sampled low: state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, done 0, fault 0 at that edge; req_ready 1 from the first edge with rst_n high.
REQ-029 Reset mid-transaction abandons the store: no done, no fault, remaining beat not issued.

Configuration
REQ-030 Macro STORE_MISALIGNED_SPLIT_EN defined: misaligned stores handled per REQ-024/REQ-025 (single beat if within one word, else split).
REQ-031 Macro undefined: S_SH with addr[0]=1 or S_SW with addr[1:0]!=0 SHALL fault; BEAT1 state unreachable and may be removed.

Structure
REQ-032 isa_shared package SHALL hold store_function3_e {S_SB=3'b000, S_SH=3'b001, S_SW=3'b010}, alongside the existing load encodings.
REQ-033 isa_shared SHALL hold the state enum store_state_e {ST_IDLE, ST_BEAT0, ST_BEAT1}.
REQ-034 Combinational sub-module store_lane_align SHALL compute beat0/beat1 wdata, wstrb and the split flag from off, funct3, data; store_unit holds FSM and registers only.

Verification
REQ-035 SW addr 0x100 data 0xDEADBEEF, mem_ready=1 -> one beat addr 0x100 wstrb 1111 wdata 0xDEADBEEF; done at N+2.
REQ-036 SB addr 0x203 data 0x000000A5 -> addr 0x200 wstrb 1000 wdata 0xA5000000; done once.
REQ-037 SW addr 0x102 data 0x11223344, macro on -> beat0 0x100/1100/0x33440000, beat1 0x104/0011/0x00001122; done at N+3; macro off -> fault at N+1, no mem_valid.
REQ-038 SH addr 0x7 data 0xBEEF, macro on, mem_ready low 3 cycles -> beat0 0x4/1000/0xEF000000 held stable, then beat1 0x8/0001/0x000000BE.
REQ-039 funct3=3'b011 -> fault pulse, no mem_valid; rst_n low during BEAT1 stall -> mem_valid 0 next edge, no done.
REQ-040 Back-to-back SB requests with req_valid held, mem_ready=1 -> one accept every 2 cycles, done each time, no dropped request.
